uart_imem_loader: RTL
=====================

# uart_imem_loader

UART boot loader that sits upstream of the pipeline CPU and fills its instruction memory from the serial `uart_rx` pin. It deserialises 8N1 bytes, recognises a sync/length header, and assembles little-endian 32-bit words into single-cycle instruction-memory writes. It holds the CPU stalled while a program is loading and releases it when the last word is written.

## Interface
- `CLKS_PER_BIT`, 104: clock cycles per UART bit; must be ≥ 4.
- `ADDR_WIDTH`, 7: instruction-memory word-address width; depth = 2^ADDR_WIDTH, 128 words by default.
- `SYNC_BYTE`, 8'h55: header byte that starts a load.
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `uart_rx` in 1: serial input, idle high, asynchronous to `clk`.
- `imem_we` out 1: one-cycle instruction-memory write strobe.
- `imem_addr` out ADDR_WIDTH: word address for the write.
- `imem_wdata` out 32: instruction word for the write.
- `cpu_hold` out 1: high while a load is in progress; the CPU must not fetch.
- `load_done` out 1: one-cycle pulse after the final word is written.
- `frame_err` out 1: sticky flag for a bad stop bit or truncated load; cleared only by `reset`.

## Operation
- RX front end:
  - `uart_rx` passes through a 2-flop synchroniser, reset value 1.
  - Bit FSM states: RX_IDLE → RX_START on a synchronised falling edge.
  - RX_START re-samples at CLKS_PER_BIT/2. If the line is high, it was a glitch: return to RX_IDLE. If low, go to RX_DATA.
  - RX_DATA samples 8 bits LSB-first, one every CLKS_PER_BIT, then goes to RX_STOP.
  - RX_STOP samples once after CLKS_PER_BIT. On 1: `byte_valid` pulses for one cycle with the byte. On 0: `byte_err` pulses and no byte is delivered. Either way, return to RX_IDLE.
- Loader FSM:
  - L_SYNC: ignores every byte except SYNC_BYTE. On SYNC_BYTE go to L_LEN and raise `cpu_hold`.
  - L_LEN: the byte is the word count N. N=0 means 2^ADDR_WIDTH words; N > 2^ADDR_WIDTH is clamped to 2^ADDR_WIDTH. Clear the address and byte-lane counters, go to L_DATA.
  - L_DATA:
    - Bytes fill a 32-bit shift register little-endian, byte 0 → [7:0].
    - On the 4th byte: pulse `imem_we` with the current `imem_addr`, clear the lane counter, increment the address.
    - On the Nth word: go to L_DONE.
  - L_DONE: lasts one cycle. Pulse `load_done`, drop `cpu_hold`, return to L_SYNC.
- Errors:
  - `byte_err` in L_LEN or L_DATA sets `frame_err`, drops `cpu_hold`, and returns to L_SYNC. Words already written stay written.
  - `byte_err` in L_SYNC sets `frame_err` only.
- Arithmetic: the address counter is ADDR_WIDTH bits and must never wrap within one load, because of the clamp. The word counter is ADDR_WIDTH+1 bits.

## Timing
- Reset values: `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_hold`=0, `load_done`=0, `frame_err`=0. Both FSMs reset to their idle states.
- Sampling points are counted from the synchronised falling edge:
  - Start bit at CLKS_PER_BIT/2.
  - Data bit k (k=0..7) at CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
  - Stop bit at CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- `byte_valid` is asserted in the cycle after the stop-bit sample.
- Output registers:
  - `imem_we`, `imem_addr` and `imem_wdata` are registered and assert the cycle after the 4th `byte_valid`. `imem_wdata` holds its value until the next write.
  - `cpu_hold` rises the cycle after the SYNC_BYTE `byte_valid`.
  - `load_done` asserts and `cpu_hold` deasserts in the cycle after the final `imem_we`.
- A new start edge may arrive in the cycle immediately after the stop sample; back-to-back bytes at full rate must not be dropped.
- Asynchronous `reset` mid-byte or mid-load aborts everything immediately: outputs go to their reset values and the partial word is discarded.

## Structure
- Shared package `loader_pkg`:
  - RX state enum: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - Loader state enum: L_SYNC, L_LEN, L_DATA, L_DONE.
  - Default SYNC_BYTE constant.
- Sub-module `uart_rx_byte`: synchroniser, bit FSM and baud counter. Outputs `byte_valid`, `byte_data[7:0]`, `byte_err`. It is reusable for other UART paths.
- `uart_imem_loader` contains the loader FSM, lane/address/word counters and output registers.

## Test plan
- CLKS_PER_BIT=8. Send 0x55, 0x01, 0x13, 0x00, 0x00, 0x00 → one `imem_we` with `imem_addr`=0, `imem_wdata`=32'h00000013. `load_done` pulses one cycle later and `cpu_hold` falls in that same cycle.
- Send 0x55, 0x02, then 8 bytes back-to-back with no idle → writes to addr 0 and 1 with the correct little-endian words, and no byte is lost.
- Send 0x55, 0x00 followed by 512 data bytes → 128 writes to addr 0..127 and a single `load_done`. Repeat with N=0xC8 → clamped to 128 writes.
- Stop bit forced low on the 3rd data byte → `frame_err`=1, `cpu_hold`=0, no further `imem_we`. A subsequent valid load still succeeds and `frame_err` stays 1.
- Low glitch of CLKS_PER_BIT/4 cycles on an idle line → no byte is delivered and the loader stays in L_SYNC. Bytes other than 0x55 in L_SYNC → ignored and `cpu_hold` stays 0.
- Assert `reset` in the middle of the 2nd word → all outputs at their reset values the same cycle. After release, a fresh load writes from addr 0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types for the UART instruction-memory loader.
// Holds the RX bit-FSM and loader-FSM state enums and the default sync byte.
package loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        L_SYNC,
        L_LEN,
        L_DATA,
        L_DONE
    } ld_state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'h55;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, bit FSM and baud counter.
// Ports: clk, reset (async high), rx (serial in, idle high),
//        byte_valid/byte_data (one-cycle good byte), byte_err (bad stop bit).
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    rx_state_e     state_q, state_d;
    logic [1:0]    sync_q;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          line;
    logic          fall;

    assign line = sync_q[1];
    assign fall = prev_q & ~line;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            prev_q  <= line;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (fall) state_d = RX_START;
            end
            RX_START: begin
                // A line that is high again mid start bit was only a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = line ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    sh_d  = {line, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                // Back to idle right at the sample so a following start
                // edge is caught without losing a byte.
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = line;
                    err_d   = ~line;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid = valid_q;
    assign byte_data  = sh_q;
    assign byte_err   = err_q;

endmodule

// File: rtl/uart_imem_loader.sv
// UART boot loader: sync/length header, then little-endian words to imem.
// Ports: clk, reset (async high), uart_rx; imem_we/imem_addr/imem_wdata,
//        cpu_hold (load in progress), load_done (pulse), frame_err (sticky).
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 104,
    parameter int          ADDR_WIDTH   = 7,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  uart_rx,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  frame_err
);

    localparam int AW    = ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (uart_rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_err  (byte_err)
    );

    ld_state_e     state_q, state_d;
    logic [1:0]    lane_q, lane_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   nw_q, nw_d;
    logic [31:0]   sh_q, sh_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          hold_q, hold_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;
    logic          last_word;

    // Last word reached: address is never incremented past it, so no wrap.
    assign last_word = ((AW+1)'(addr_q) + (AW+1)'(1)) == nw_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= L_SYNC;
            lane_q  <= '0;
            addr_q  <= '0;
            nw_q    <= '0;
            sh_q    <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            nw_q    <= nw_d;
            sh_q    <= sh_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        addr_d  = addr_q;
        nw_d    = nw_q;
        sh_d    = sh_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q | byte_err;
        unique case (state_q)
            L_SYNC: begin
                if (byte_valid && byte_data == SYNC_BYTE) begin
                    state_d = L_LEN;
                    hold_d  = 1'b1;
                end
            end
            L_LEN: begin
                if (byte_err) begin
                    state_d = L_SYNC;
                    hold_d  = 1'b0;
                end else if (byte_valid) begin
                    // Zero and oversize counts both mean a full memory.
                    if (byte_data == 8'd0 || 32'(byte_data) > 32'(DEPTH))
                        nw_d = (AW+1)'(DEPTH);
                    else
                        nw_d = (AW+1)'(byte_data);
                    addr_d  = '0;
                    lane_d  = '0;
                    state_d = L_DATA;
                end
            end
            L_DATA: begin
                if (byte_err) begin
                    state_d = L_SYNC;
                    hold_d  = 1'b0;
                end else if (byte_valid) begin
                    sh_d   = {byte_data, sh_q[31:8]};
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = sh_d;
                        lane_d  = '0;
                        if (last_word) state_d = L_DONE;
                        else           addr_d  = addr_q + AW'(1);
                    end
                end
            end
            L_DONE: begin
                done_d  = 1'b1;
                hold_d  = 1'b0;
                state_d = L_SYNC;
            end
            default: state_d = L_SYNC;
        endcase
    end

    assign imem_we    = we_q;
    assign imem_addr  = waddr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign frame_err  = ferr_q;

endmodule
